fetch_ctrl: RTL
===============

# fetch_ctrl

Fetch-stage sequencer that owns the program counter driving the instruction memory in the P7 MIPS core. Selects each cycle between sequential fetch, branch/jump redirect, interrupt vectoring into the handler region at 0x0000_4180, and eret return. Tracks whether fetch is inside the handler so interrupts do not nest. Sits between the NPC/branch logic and CP0 on one side and the instruction memory address port on the other.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset
- HANDLER_PC, 32'h0000_4180, interrupt/exception vector; start of handler region
- HANDLER_END, 32'h0000_44E0, last valid word address of handler region
- CODE_END, 32'h0000_417C, last valid word address of main code region
- clk  input  1  system clock; all state changes on posedge
- reset  input  1  synchronous, active-high
- stall  input  1  hazard stall; freezes PC and state
- redirect  input  1  branch/jump taken this cycle
- redirect_pc  input  32  target for redirect
- int_req  input  1  level interrupt request from CP0
- eret  input  1  eret decoded in fetch-relevant stage
- epc_in  input  32  return address from CP0
- pc  output  32  current fetch address to instruction memory
- int_ack  output  1  one-cycle pulse: vector taken
- epc_out  output  32  PC of the interrupted (not yet executed) instruction, valid with int_ack
- in_handler  output  1  fetch is in handler state
- fetch_fault  output  1  fault pulse (only with FETCH_ALIGN_CHECK_EN)
- exc_code  output  5  5'd4 (AdEL) with fetch_fault, else 0

## Operation
- States: NORMAL, HANDLER. Reset: state NORMAL, pc=RESET_PC, int_ack=0, epc_out=0, in_handler=0, fetch_fault=0, exc_code=0.
- Priority on each posedge: reset > stall > vector > eret > redirect > pc+4.
- stall=1: pc, state, epc_out hold; int_ack/fetch_fault drop to 0; int_req stays pending (level).
- Vector: NORMAL and int_req=1 -> pc<=HANDLER_PC, epc_out<=pc, state<=HANDLER, int_ack<=1 next cycle.
- In HANDLER, int_req ignored (no nesting).
- eret in HANDLER: pc<=epc_in, state<=NORMAL. eret in NORMAL: ignored, falls through to redirect/pc+4.
- Vector and redirect same cycle: vector wins; epc_out=current pc; redirect dropped (CP0/NPC re-issue is the caller's job).
- eret and redirect same cycle in HANDLER: eret wins.
- pc+4 wraps modulo 2^32; no saturation.
- in_handler = (state==HANDLER), registered.

## Timing
- pc is registered; memory read is combinational from pc, so instruction valid same cycle as pc.
- Vector latency: int_req sampled high at edge N -> pc==HANDLER_PC and int_ack=1 during cycle N+1; int_ack low in N+2.
- eret latency: one edge -> pc==epc_in, in_handler=0.
- Reset mid-handler: next cycle pc=RESET_PC, state NORMAL, pending int_req taken on the following edge.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: next-PC is checked before commit; misaligned (bits[1:0]!=0) or outside [RESET_PC,CODE_END]∪[HANDLER_PC,HANDLER_END] -> pc<=HANDLER_PC, epc_out<=offending address, state<=HANDLER, fetch_fault=1 and exc_code=5'd4 for one cycle. A fault in HANDLER state also vectors (restart handler). Fault outranks vector.
- Undefined: no check; fetch_fault and exc_code tied 0; any address is fetched.

## Structure
- Package fetch_pkg: state enum (NORMAL, HANDLER), RESET_PC/HANDLER_PC/HANDLER_END/CODE_END defaults, EXC_ADEL=5'd4.
- One sub-module: pc_range_chk (combinational alignment/range check, instantiated only under FETCH_ALIGN_CHECK_EN).

## Test plan
- Reset then 4 free cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; in_handler=0.
- pc=0x3010, int_req=1 one cycle -> next pc=0x4180, int_ack=1, epc_out=0x3010, in_handler=1; int_ack=0 next cycle.
- In HANDLER, int_req held high, eret with epc_in=0x3010 -> pc 0x3010, in_handler=0; next edge re-vectors to 0x4180.
- int_req=1 with stall=1 for 3 cycles -> pc frozen, int_ack=0; stall drop -> vector on next edge.
- Same cycle int_req and redirect to 0x3200 at pc=0x3020 -> pc=0x4180, epc_out=0x3020.
- With FETCH_ALIGN_CHECK_EN, redirect_pc=0x3002 -> pc=0x4180, fetch_fault=1, exc_code=4, epc_out=0x3002; without macro -> pc=0x3002.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and address map for the fetch sequencer.
// Optional fetch address check: FETCH_ALIGN_CHECK_EN.
package fetch_pkg;

    typedef enum logic {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC    = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC  = 32'h0000_4180;
    localparam logic [31:0] HANDLER_END = 32'h0000_44E0;
    localparam logic [31:0] CODE_END    = 32'h0000_417C;
    localparam logic [4:0]  EXC_ADEL    = 5'd4;

endpackage

// File: rtl/pc_range_chk.sv
// Combinational check of a candidate fetch address:
// flags misalignment or an address outside code/handler regions.
module pc_range_chk
    import fetch_pkg::*;
(
    input  logic [31:0] addr,
    output logic        bad
);

    logic in_code;
    logic in_hdlr;

    always_comb begin
        in_code = (addr >= RESET_PC) && (addr <= CODE_END);
        in_hdlr = (addr >= HANDLER_PC) && (addr <= HANDLER_END);
        bad     = (addr[1:0] != 2'b00) || !(in_code || in_hdlr);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer: sequential, redirect, interrupt vector, eret.
// Optional fetch address check: FETCH_ALIGN_CHECK_EN.
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        int_req,
    input  logic        eret,
    input  logic [31:0] epc_in,
    output logic [31:0] pc,
    output logic        int_ack,
    output logic [31:0] epc_out,
    output logic        in_handler,
    output logic        fetch_fault,
    output logic [4:0]  exc_code
);

    state_t      state;
    state_t      state_n;
    logic [31:0] pc_n;
    logic [31:0] epc_n;
    logic [31:0] seq_pc;
    logic        ack_n;
    logic        do_eret;
    logic        bad;

    assign do_eret = (state == HANDLER) && eret;

    // Non-vector successor: eret outranks redirect, redirect outranks pc+4
    always_comb begin
        seq_pc = pc + 32'd4;
        if (do_eret)
            seq_pc = epc_in;
        else if (redirect)
            seq_pc = redirect_pc;
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic flt_q;

    pc_range_chk u_chk (
        .addr (seq_pc),
        .bad  (bad)
    );

    always_ff @(posedge clk) begin
        if (reset)
            flt_q <= 1'b0;
        else
            flt_q <= !stall && bad;
    end

    assign fetch_fault = flt_q;
    assign exc_code    = flt_q ? EXC_ADEL : 5'd0;
`else
    assign bad         = 1'b0;
    assign fetch_fault = 1'b0;
    assign exc_code    = 5'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= NORMAL;
            pc      <= RESET_PC;
            epc_out <= 32'd0;
            int_ack <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            epc_out <= epc_n;
            int_ack <= ack_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        epc_n   = epc_out;
        ack_n   = 1'b0;
        if (!stall) begin
            if (bad) begin
                state_n = HANDLER;
                pc_n    = HANDLER_PC;
                epc_n   = seq_pc;
            end else if (state == NORMAL && int_req) begin
                state_n = HANDLER;
                pc_n    = HANDLER_PC;
                epc_n   = pc;
                ack_n   = 1'b1;
            end else begin
                pc_n = seq_pc;
                if (do_eret)
                    state_n = NORMAL;
            end
        end
    end

    always_comb begin
        in_handler = (state == HANDLER);
    end

endmodule
